// File: rtl/tmc_pkg.sv
// tmc_pkg: shared constants and types for the TMC block-RAM register file.
// Provides the default RAM geometry, the requester index map, and the
// arbiter state type used by tmc_bram_port_arbiter.
package tmc_pkg;

    localparam int TMC_MEM_AW = 6;
    localparam int TMC_MEM_DW = 32;
    localparam int TMC_NREQ   = 4;

    localparam int REQ_HOST  = 0;
    localparam int REQ_SPIM  = 1;
    localparam int REQ_STEP0 = 2;
    localparam int REQ_STEP1 = 3;

    typedef enum logic {
        ARB_FREE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/tmc_rr_pick.sv
// tmc_rr_pick: combinational rotate-priority encoder.
// Ports:
//   elig  in  NREQ  requesters allowed to win this cycle
//   ptr   in  IW    index of the previous winner; search starts at ptr+1
//   found out 1     at least one eligible requester
//   idx   out IW    winning requester index (0 when nothing found)
module tmc_rr_pick
    import tmc_pkg::*;
#(
    parameter int NREQ = TMC_NREQ,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    // Walk ptr+1, ptr+2, ... wrapping modulo NREQ, and keep the first
    // eligible requester; the previous winner therefore has lowest priority.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tmc_bram_port_arbiter.sv
// tmc_bram_port_arbiter: round-robin arbiter sharing one port of the 64x32
// block-RAM register file between NREQ requesters, with a lock for atomic
// read-modify-write and a watchdog that breaks abandoned locks.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req/we/lock           per-requester access request, write flag, keep-ownership flag
//   addr/wdata            packed per-requester word address and write data
//   gnt                   one-cycle grant pulse (one-hot or zero)
//   rvalid/rdata          one-cycle read-valid pulse per requester, shared read data
//   lock_err              one-cycle pulse when the watchdog releases a lock
//   mem_en/we/addr/din    registered RAM port controls
//   mem_dout              RAM read data, one cycle after the enabled access
module tmc_bram_port_arbiter
    import tmc_pkg::*;
#(
    parameter int NREQ    = TMC_NREQ,
    parameter int AW      = TMC_MEM_AW,
    parameter int DW      = TMC_MEM_DW,
    parameter int LOCK_TO = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               lock_err,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(LOCK_TO + 1);

    arb_state_t      state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [WW-1:0]   wdog;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] owner_mask;
    logic [NREQ-1:0] win_onehot;
    logic            found;
    logic [IW-1:0]   win;

    // A requester whose grant is showing this cycle is still holding req for
    // that same access, so it must sit out one edge. While a lock is held,
    // only the owner may compete.
    always_comb begin
        owner_mask = '0;
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner_mask[i] = (owner == IW'(i));
            win_onehot[i] = (win == IW'(i));
        end
        elig = req & ~gnt;
        if (state == ARB_OWNED) begin
            elig = elig & owner_mask;
        end
    end

    tmc_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    assign rdata = mem_dout;

    // Registered RAM port mux, grant/rvalid pulses, lock state and watchdog.
    // A read issued this cycle (gnt with mem_we low) becomes rvalid next
    // cycle, which lines up with the RAM's one-cycle read latency. The
    // watchdog only releases a lock on an edge where the owner is not being
    // granted; that edge still arbitrates under the old ownership, so other
    // requesters compete from the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_FREE;
            owner    <= '0;
            ptr      <= IW'(NREQ - 1);
            wdog     <= '0;
            gnt      <= '0;
            rvalid   <= '0;
            lock_err <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            rvalid   <= gnt & {NREQ{~mem_we}};
            gnt      <= '0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            lock_err <= 1'b0;
            if (found) begin
                gnt      <= win_onehot;
                mem_en   <= 1'b1;
                mem_we   <= we[win];
                mem_addr <= addr[int'(win)*AW +: AW];
                mem_din  <= wdata[int'(win)*DW +: DW];
                ptr      <= win;
                wdog     <= '0;
                if (lock[win]) begin
                    state <= ARB_OWNED;
                    owner <= win;
                end else begin
                    state <= ARB_FREE;
                end
            end else if (state == ARB_OWNED) begin
                if (wdog == WW'(LOCK_TO - 1)) begin
                    state    <= ARB_FREE;
                    lock_err <= 1'b1;
                    wdog     <= '0;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmc_bram_port_arbiter.sv
// tb_tmc_bram_port_arbiter: self-checking bench for tmc_bram_port_arbiter.
// Drives a behavioural RAM on the memory port, runs a table of single
// accesses, hand-written multi-cycle sequences, and a randomized phase
// checked against a reference model of the arbitration rules.
module tb_tmc_bram_port_arbiter;
    import tmc_pkg::*;

    localparam int NREQ    = 4;
    localparam int AW      = 6;
    localparam int DW      = 32;
    localparam int LOCK_TO = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               lock_err;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_din;
    logic [DW-1:0]      mem_dout;

    logic [DW-1:0] ram     [64];
    logic [DW-1:0] ref_ram [64];

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int          rq;
        logic        w;
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];
    int   gcount [NREQ];

    int          last;
    int          owner;
    int          idle;
    int          winner;
    int          j;
    logic [3:0]  eg;
    logic [3:0]  erv;
    logic [3:0]  ng;
    logic [3:0]  nrv;
    logic        ewe;
    logic        nwe;
    logic        elerr;
    logic        nlerr;
    logic [31:0] erd_c;
    logic [31:0] erdata;
    logic [31:0] nrd;
    logic [5:0]  ma;

    always #5 clk = ~clk;

    tmc_bram_port_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .LOCK_TO (LOCK_TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .lock     (lock),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .lock_err (lock_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    // Single-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_din;
            end
            mem_dout <= ram[mem_addr];
        end
    end

    function automatic logic [31:0] seedWord(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int i, input logic w, input logic l, input logic [5:0] a, input logic [31:0] d);
        req[i]             = 1'b1;
        we[i]              = w;
        lock[i]            = l;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
    endtask

    task automatic dropReq(input int i);
        req[i]  = 1'b0;
        we[i]   = 1'b0;
        lock[i] = 1'b0;
    endtask

    task automatic randomRequest(input int i);
        applyStimulus(i, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
                      6'($urandom_range(7, 0)), $urandom());
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        we       = '0;
        lock     = '0;
        addr     = '0;
        wdata    = '0;
        mem_dout = '0;
        for (int i = 0; i < 64; i++) begin
            ram[i]     = seedWord(i);
            ref_ram[i] = seedWord(i);
        end
        ram[5]     = 32'hCAFE0001;
        ref_ram[5] = 32'hCAFE0001;

        vecs[0] = '{1, 1'b0, 6'h05, 32'h0, 32'hCAFE0001};
        vecs[1] = '{0, 1'b1, 6'h3F, 32'h5A5A5A5A, 32'h0};
        vecs[2] = '{0, 1'b0, 6'h3F, 32'h0, 32'h5A5A5A5A};
        vecs[3] = '{3, 1'b1, 6'h00, 32'hA5A50F0F, 32'h0};
        vecs[4] = '{3, 1'b0, 6'h00, 32'h0, 32'hA5A50F0F};
        vecs[5] = '{2, 1'b0, 6'h3F, 32'h0, 32'h5A5A5A5A};
        vecs[6] = '{1, 1'b1, 6'h15, 32'hDEADBEEF, 32'h0};
        vecs[7] = '{2, 1'b0, 6'h15, 32'h0, 32'hDEADBEEF};

        // Reset state.
        tick;
        tick;
        checkOutput("reset gnt", 32'(gnt), 32'h0);
        checkOutput("reset rvalid", 32'(rvalid), 32'h0);
        checkOutput("reset lock_err", 32'(lock_err), 32'h0);
        checkOutput("reset mem_en", 32'(mem_en), 32'h0);
        checkOutput("reset mem_we", 32'(mem_we), 32'h0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("reset mem_din", mem_din, 32'h0);
        reset = 1'b0;

        // Table of isolated single accesses.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k].rq, vecs[k].w, 1'b0, vecs[k].a, vecs[k].d);
            if (vecs[k].w) begin
                ref_ram[vecs[k].a] = vecs[k].d;
            end
            tick;
            checkOutput($sformatf("vec%0d gnt", k), 32'(gnt), 32'(1) << vecs[k].rq);
            checkOutput($sformatf("vec%0d mem_en", k), 32'(mem_en), 32'h1);
            checkOutput($sformatf("vec%0d mem_we", k), 32'(mem_we), 32'(vecs[k].w));
            checkOutput($sformatf("vec%0d mem_addr", k), 32'(mem_addr), 32'(vecs[k].a));
            if (vecs[k].w) begin
                checkOutput($sformatf("vec%0d mem_din", k), mem_din, vecs[k].d);
            end
            dropReq(vecs[k].rq);
            tick;
            checkOutput($sformatf("vec%0d rvalid", k), 32'(rvalid),
                        vecs[k].w ? 32'h0 : (32'(1) << vecs[k].rq));
            if (!vecs[k].w) begin
                checkOutput($sformatf("vec%0d rdata", k), rdata, vecs[k].exp_rdata);
            end
            tick;
        end

        // Write then read-back by one requester: second grant exactly 2 cycles later.
        applyStimulus(0, 1'b1, 1'b0, 6'h3F, 32'h12345678);
        ref_ram[6'h3F] = 32'h12345678;
        tick;
        checkOutput("wr gnt", 32'(gnt), 32'h1);
        applyStimulus(0, 1'b0, 1'b0, 6'h3F, 32'h0);
        tick;
        checkOutput("wr gap", 32'(gnt), 32'h0);
        tick;
        checkOutput("rd gnt", 32'(gnt), 32'h1);
        dropReq(0);
        tick;
        checkOutput("rd rvalid", 32'(rvalid), 32'h1);
        checkOutput("rd rdata", rdata, 32'h12345678);
        tick;

        // All requesters reading continuously from reset.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            applyStimulus(i, 1'b0, 1'b0, 6'(i), 32'h0);
            gcount[i] = 0;
        end
        for (int k = 0; k < 16; k++) begin
            tick;
            checkOutput($sformatf("rr%0d gnt", k), 32'(gnt), 32'(1) << (k % 4));
            checkOutput($sformatf("rr%0d mem_en", k), 32'(mem_en), 32'h1);
            if (k > 0) begin
                checkOutput($sformatf("rr%0d rvalid", k), 32'(rvalid), 32'(1) << ((k - 1) % 4));
                checkOutput($sformatf("rr%0d rdata", k), rdata, ref_ram[(k - 1) % 4]);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    gcount[i]++;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            checkOutput($sformatf("rr count%0d", i), 32'(gcount[i]), 32'd4);
            dropReq(i);
        end
        tick;
        tick;

        // Locked read-modify-write by requester 2 while 0 and 3 wait.
        applyStimulus(2, 1'b0, 1'b1, 6'h10, 32'h0);
        tick;
        checkOutput("lk rd gnt", 32'(gnt), 32'h4);
        applyStimulus(2, 1'b1, 1'b0, 6'h10, 32'h00000077);
        applyStimulus(0, 1'b0, 1'b0, 6'h11, 32'h0);
        applyStimulus(3, 1'b0, 1'b0, 6'h12, 32'h0);
        tick;
        checkOutput("lk hold gnt", 32'(gnt), 32'h0);
        checkOutput("lk rd rvalid", 32'(rvalid), 32'h4);
        checkOutput("lk rd rdata", rdata, ref_ram[6'h10]);
        tick;
        checkOutput("lk wr gnt", 32'(gnt), 32'h4);
        checkOutput("lk wr mem_we", 32'(mem_we), 32'h1);
        ref_ram[6'h10] = 32'h00000077;
        dropReq(2);
        tick;
        checkOutput("lk next gnt", 32'(gnt), 32'h8);
        dropReq(3);
        tick;
        checkOutput("lk then gnt", 32'(gnt), 32'h1);
        dropReq(0);
        tick;
        tick;

        // Abandoned lock released by the watchdog.
        applyStimulus(1, 1'b0, 1'b1, 6'h01, 32'h0);
        tick;
        checkOutput("wd lock gnt", 32'(gnt), 32'h2);
        dropReq(1);
        applyStimulus(0, 1'b0, 1'b0, 6'h02, 32'h0);
        for (int k = 1; k <= LOCK_TO; k++) begin
            tick;
            checkOutput($sformatf("wd%0d lock_err", k), 32'(lock_err), 32'(k == LOCK_TO));
            checkOutput($sformatf("wd%0d gnt", k), 32'(gnt), 32'h0);
        end
        tick;
        checkOutput("wd after gnt", 32'(gnt), 32'h1);
        checkOutput("wd after lock_err", 32'(lock_err), 32'h0);
        dropReq(0);
        tick;
        tick;

        // Reset in the cycle after a read grant drops the rvalid.
        applyStimulus(2, 1'b0, 1'b0, 6'h03, 32'h0);
        tick;
        checkOutput("rst rd gnt", 32'(gnt), 32'h4);
        reset = 1'b1;
        dropReq(2);
        tick;
        checkOutput("rst rvalid", 32'(rvalid), 32'h0);
        checkOutput("rst gnt", 32'(gnt), 32'h0);
        checkOutput("rst mem_en", 32'(mem_en), 32'h0);
        checkOutput("rst mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst lock_err", 32'(lock_err), 32'h0);
        reset = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 6'h04, 32'h0);
        applyStimulus(3, 1'b0, 1'b0, 6'h05, 32'h0);
        tick;
        checkOutput("rst first gnt", 32'(gnt), 32'h1);
        dropReq(0);
        tick;
        checkOutput("rst second gnt", 32'(gnt), 32'h8);
        dropReq(3);
        tick;
        tick;

        // Randomized traffic against the reference model.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        last   = NREQ - 1;
        owner  = -1;
        idle   = 0;
        eg     = '0;
        ewe    = 1'b0;
        erd_c  = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (eg[i]) begin
                        if ($urandom_range(1, 0) == 0) begin
                            dropReq(i);
                        end else begin
                            randomRequest(i);
                        end
                    end
                end else if ($urandom_range(4, 0) == 0) begin
                    randomRequest(i);
                end
            end

            nrv    = (eg != 0 && !ewe) ? eg : 4'h0;
            nrd    = erd_c;
            ng     = '0;
            nwe    = 1'b0;
            nlerr  = 1'b0;
            winner = -1;
            for (int k = 1; k <= NREQ; k++) begin
                j = (last + k) % NREQ;
                if (winner < 0 && req[j] && !eg[j] && (owner < 0 || owner == j)) begin
                    winner = j;
                end
            end
            if (winner >= 0) begin
                ng[winner] = 1'b1;
                last       = winner;
                nwe        = we[winner];
                ma         = addr[winner*AW +: AW];
                if (we[winner]) begin
                    ref_ram[ma] = wdata[winner*DW +: DW];
                end else begin
                    erd_c = ref_ram[ma];
                end
                owner = lock[winner] ? winner : -1;
                idle  = 0;
            end else if (owner >= 0) begin
                idle++;
                if (idle == LOCK_TO) begin
                    owner = -1;
                    idle  = 0;
                    nlerr = 1'b1;
                end
            end
            eg     = ng;
            ewe    = nwe;
            erv    = nrv;
            erdata = nrd;
            elerr  = nlerr;

            tick;
            checkOutput($sformatf("rnd%0d gnt", n), 32'(gnt), 32'(eg));
            checkOutput($sformatf("rnd%0d rvalid", n), 32'(rvalid), 32'(erv));
            checkOutput($sformatf("rnd%0d lock_err", n), 32'(lock_err), 32'(elerr));
            if (erv != 0) begin
                checkOutput($sformatf("rnd%0d rdata", n), rdata, erdata);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            dropReq(i);
        end
        tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
